// File: rtl/router_synchronizer_pkg.sv
// Shared encodings and timing constants for the router synchronizer.
// Holds the destination address codes and the soft-reset timeout length.
package router_synchronizer_pkg;

    typedef enum logic [1:0] {
        ADDR_FIFO0   = 2'b00,
        ADDR_FIFO1   = 2'b01,
        ADDR_FIFO2   = 2'b10,
        ADDR_INVALID = 2'b11
    } addr_e;

    localparam int TIMEOUT_CYCLES = 30;
    localparam int CNT_W          = 5;

    // Count value seen on the last idle edge before the pulse fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

endpackage

// File: rtl/router_soft_rst_timer.sv
// Per-channel idle timeout: pulses soft_rst after 30 idle cycles.
// Ports: clk, rstn (sync active-high), valid, re in; soft_rst out.
module router_soft_rst_timer
    import router_synchronizer_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic valid,
    input  logic re,
    output logic soft_rst
);

    logic [CNT_W-1:0] cnt;
    logic             idle;

    // Data waiting but nobody reading it.
    assign idle = valid & ~re;

    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end else if (!idle) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            // 30th consecutive idle edge: fire once, restart the window.
            cnt      <= '0;
            soft_rst <= 1'b1;
        end else begin
            cnt      <= cnt + 1'b1;
            soft_rst <= 1'b0;
        end
    end

endmodule

// File: rtl/router_synchronizer.sv
// Router synchronizer: latches header address, decodes FIFO write
// enables / full flag, and runs three idle-timeout soft resets.
// Ports: detect_addr, write_enb_reg, clk, rstn, din[1:0], re_x, empty_x,
// full_x in; fifo_full, we[2:0], soft_rst_x, valid_out_x out.
module router_synchronizer
    import router_synchronizer_pkg::*;
(
    input  logic       detect_addr,
    input  logic       write_enb_reg,
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] din,
    input  logic       re_0,
    input  logic       re_1,
    input  logic       re_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic       fifo_full,
    output logic [2:0] we,
    output logic       soft_rst_0,
    output logic       soft_rst_1,
    output logic       soft_rst_2,
    output logic       valid_out_0,
    output logic       valid_out_1,
    output logic       valid_out_2
);

    addr_e addr;

    always_ff @(posedge clk) begin
        if (rstn) begin
            addr <= ADDR_INVALID;
        end else if (detect_addr) begin
            addr <= addr_e'(din);
        end
    end

    // Decode uses the registered address, so a header arriving in the
    // same cycle as a write does not redirect that write.
    always_comb begin
        we        = 3'b000;
        fifo_full = 1'b0;
        unique case (addr)
            ADDR_FIFO0: begin
                we        = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            ADDR_FIFO1: begin
                we        = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            ADDR_FIFO2: begin
                we        = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                we        = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign valid_out_0 = ~empty_0;
    assign valid_out_1 = ~empty_1;
    assign valid_out_2 = ~empty_2;

    router_soft_rst_timer u_tmr_0 (
        .clk      (clk),
        .rstn     (rstn),
        .valid    (valid_out_0),
        .re       (re_0),
        .soft_rst (soft_rst_0)
    );

    router_soft_rst_timer u_tmr_1 (
        .clk      (clk),
        .rstn     (rstn),
        .valid    (valid_out_1),
        .re       (re_1),
        .soft_rst (soft_rst_1)
    );

    router_soft_rst_timer u_tmr_2 (
        .clk      (clk),
        .rstn     (rstn),
        .valid    (valid_out_2),
        .re       (re_2),
        .soft_rst (soft_rst_2)
    );

endmodule

// File: tb/tb_router_synchronizer.sv
// Self-checking bench for router_synchronizer: address decode table
// plus multi-cycle soft-reset timeout sequences.
module tb_router_synchronizer;

    logic       detect_addr;
    logic       write_enb_reg;
    logic       clk;
    logic       rstn;
    logic [1:0] din;
    logic       re_0, re_1, re_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic       fifo_full;
    logic [2:0] we;
    logic       soft_rst_0, soft_rst_1, soft_rst_2;
    logic       valid_out_0, valid_out_1, valid_out_2;

    int n_chk  = 0;
    int n_fail = 0;

    router_synchronizer dut (
        .detect_addr   (detect_addr),
        .write_enb_reg (write_enb_reg),
        .clk           (clk),
        .rstn          (rstn),
        .din           (din),
        .re_0          (re_0),
        .re_1          (re_1),
        .re_2          (re_2),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .fifo_full     (fifo_full),
        .we            (we),
        .soft_rst_0    (soft_rst_0),
        .soft_rst_1    (soft_rst_1),
        .soft_rst_2    (soft_rst_2),
        .valid_out_0   (valid_out_0),
        .valid_out_1   (valid_out_1),
        .valid_out_2   (valid_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] din;
        logic       wen;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_valid;
    } vec_t;

    vec_t       vecs [10];
    vec_t       vq [$];
    logic [2:0] sq [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    // Pop the expected soft_rst triple and compare after an edge.
    task automatic check_soft(input string name);
        logic [2:0] e;
        if (sq.size() == 0) begin
            check({name, "_sq_empty"}, 1, 0);
        end else begin
            e = sq.pop_front();
            check(name, {soft_rst_2, soft_rst_1, soft_rst_0}, e);
        end
    endtask

    initial begin
        vec_t v;
        // din wen full   empty  we     ff   valid
        vecs[0] = '{2'b00, 1'b1, 3'b100, 3'b111, 3'b001, 1'b0, 3'b000};
        vecs[1] = '{2'b00, 1'b1, 3'b001, 3'b110, 3'b001, 1'b1, 3'b001};
        vecs[2] = '{2'b00, 1'b0, 3'b001, 3'b101, 3'b000, 1'b1, 3'b010};
        vecs[3] = '{2'b01, 1'b1, 3'b010, 3'b011, 3'b010, 1'b1, 3'b100};
        vecs[4] = '{2'b01, 1'b1, 3'b101, 3'b000, 3'b010, 1'b0, 3'b111};
        vecs[5] = '{2'b10, 1'b1, 3'b100, 3'b010, 3'b100, 1'b1, 3'b101};
        vecs[6] = '{2'b10, 1'b1, 3'b011, 3'b111, 3'b100, 1'b0, 3'b000};
        vecs[7] = '{2'b10, 1'b0, 3'b100, 3'b111, 3'b000, 1'b1, 3'b000};
        vecs[8] = '{2'b11, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[9] = '{2'b11, 1'b0, 3'b111, 3'b001, 3'b000, 1'b0, 3'b110};

        detect_addr   = 1'b0;
        write_enb_reg = 1'b0;
        rstn          = 1'b1;
        din           = 2'b00;
        {re_2, re_1, re_0}          = 3'b000;
        {empty_2, empty_1, empty_0} = 3'b111;
        {full_2, full_1, full_0}    = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;

        // Reset state, including write request with no address loaded.
        write_enb_reg = 1'b1;
        {full_2, full_1, full_0} = 3'b111;
        #1;
        check("rst_we", we, 3'b000);
        check("rst_ff", fifo_full, 1'b0);
        check("rst_valid", {valid_out_2, valid_out_1, valid_out_0}, 3'b000);
        check("rst_soft", {soft_rst_2, soft_rst_1, soft_rst_0}, 3'b000);
        write_enb_reg = 1'b0;
        {full_2, full_1, full_0} = 3'b000;

        // Decode table: load address, then apply write/full/empty.
        foreach (vecs[i]) begin
            @(negedge clk);
            detect_addr   = 1'b1;
            din           = vecs[i].din;
            write_enb_reg = 1'b0;
            @(negedge clk);
            detect_addr   = 1'b0;
            din           = ~vecs[i].din;
            write_enb_reg = vecs[i].wen;
            {full_2, full_1, full_0}    = vecs[i].full;
            {empty_2, empty_1, empty_0} = vecs[i].empty;
            vq.push_back(vecs[i]);
            #1;
            v = vq.pop_front();
            check($sformatf("tbl%0d_we", i), we, v.exp_we);
            check($sformatf("tbl%0d_ff", i), fifo_full, v.exp_ff);
            check($sformatf("tbl%0d_valid", i),
                  {valid_out_2, valid_out_1, valid_out_0}, v.exp_valid);
        end

        // Header and write together: write goes to the old address.
        @(negedge clk);
        detect_addr = 1'b1;
        din = 2'b00;
        write_enb_reg = 1'b0;
        @(negedge clk);
        din = 2'b10;
        write_enb_reg = 1'b1;
        {full_2, full_1, full_0} = 3'b001;
        #1;
        check("same_cyc_we_old", we, 3'b001);
        check("same_cyc_ff_old", fifo_full, 1'b1);
        @(posedge clk);
        #1;
        check("same_cyc_we_new", we, 3'b100);
        check("same_cyc_ff_new", fifo_full, 1'b0);
        @(negedge clk);
        detect_addr = 1'b0;
        write_enb_reg = 1'b0;
        {full_2, full_1, full_0} = 3'b000;
        {empty_2, empty_1, empty_0} = 3'b111;

        // Reset returns address to invalid.
        do_reset();
        write_enb_reg = 1'b1;
        #1;
        check("post_rst_we", we, 3'b000);
        write_enb_reg = 1'b0;

        // Channels 0 and 1 idle together: pulses at edges 30 and 60.
        @(negedge clk);
        {empty_2, empty_1, empty_0} = 3'b100;
        {re_2, re_1, re_0} = 3'b000;
        for (int k = 1; k <= 65; k++) begin
            logic p;
            p = (k == 30) || (k == 60);
            sq.push_back({1'b0, p, p});
            @(posedge clk);
            #1;
            check_soft($sformatf("idle01_k%0d", k));
        end

        // Read at edge 20 restarts the window: pulse at edge 50.
        @(negedge clk);
        {empty_2, empty_1, empty_0} = 3'b110;
        re_0 = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 55; k++) begin
            re_0 = (k == 20);
            sq.push_back({2'b00, k == 50});
            @(posedge clk);
            #1;
            check_soft($sformatf("re20_k%0d", k));
            @(negedge clk);
        end

        // Reset at idle edge 15 discards count: pulse at edge 45.
        re_0 = 1'b1;
        @(negedge clk);
        re_0 = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            rstn = (k == 15);
            sq.push_back({2'b00, k == 45});
            @(posedge clk);
            #1;
            check_soft($sformatf("rst15_k%0d", k));
            @(negedge clk);
        end
        rstn = 1'b0;

        // Channel 2 valid but continuously read: never times out.
        {empty_2, empty_1, empty_0} = 3'b011;
        {re_2, re_1, re_0} = 3'b100;
        for (int k = 1; k <= 100; k++) begin
            sq.push_back(3'b000);
            @(posedge clk);
            #1;
            check_soft($sformatf("read2_k%0d", k));
            if (k % 25 == 0) check("read2_valid", valid_out_2, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
